// File: rtl/excp_unit.sv
// Exception arbiter and pipeline-reset sequencer: picks one cause by fixed priority,
// issues a one-cycle entry strobe, and stretches pipeline reset / post-entry flush.
module excp_unit #(
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [31:0] RESET_VEC    = 32'hBFC00000,
  parameter logic [31:0] REFILL_VEC   = 32'h80000000,
  parameter logic [31:0] GENERAL_VEC  = 32'h80000180
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ERET,
  input  logic        INT_COUNTER,
  input  logic        SYSCALL,
  input  logic        BREAK,
  input  logic        RI,
  input  logic        CpU,
  input  logic        OV,
  input  logic        dTLBMOD,
  input  logic        dTLBL,
  input  logic        dTLBS,
  input  logic        dADEL,
  input  logic        dADES,
  input  logic        iTLBL,
  input  logic        iADEL,
  input  logic        IBE,
  input  logic        DBE,
  input  logic [31:0] PC_WB,
  input  logic        DELAY_SLOT,
  output logic        E_ENTER,
  output logic        PIPE_RESET,
  output logic [31:0] VECTOR,
  output logic [31:0] EPC,
  output logic [4:0]  CAUSE
);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] RST_LAST   = 4'(RST_CYCLES - 1);
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  // Bit 0 is the highest-priority flag; fetch-side faults beat execute and data faults.
  function automatic logic [4:0] sel_cause(input logic [13:0] f);
    logic [4:0] code;
    if      (f[0])  code = 5'd4;   // iADEL
    else if (f[1])  code = 5'd2;   // iTLBL
    else if (f[2])  code = 5'd6;   // IBE
    else if (f[3])  code = 5'd11;  // CpU
    else if (f[4])  code = 5'd10;  // RI
    else if (f[5])  code = 5'd12;  // OV
    else if (f[6])  code = 5'd8;   // SYSCALL
    else if (f[7])  code = 5'd9;   // BREAK
    else if (f[8])  code = 5'd4;   // dADEL
    else if (f[9])  code = 5'd5;   // dADES
    else if (f[10]) code = 5'd2;   // dTLBL
    else if (f[11]) code = 5'd3;   // dTLBS
    else if (f[12]) code = 5'd1;   // dTLBMOD
    else if (f[13]) code = 5'd7;   // DBE
    else            code = 5'd0;   // counter interrupt
    return code;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        e_enter_q, e_enter_d;
  logic        pipe_reset_q, pipe_reset_d;
  logic [31:0] vector_q, vector_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  cause_q, cause_d;

  logic [13:0] sync_flags_s;
  logic        req_s;
  logic [4:0]  code_s;

  assign sync_flags_s = {DBE, dTLBMOD, dTLBS, dTLBL, dADES, dADEL,
                         BREAK, SYSCALL, OV, RI, CpU, IBE, iTLBL, iADEL};
  assign req_s  = (|sync_flags_s) | INT_COUNTER;
  assign code_s = sel_cause(sync_flags_s);

  // Next-state and output computation for the reset / run / flush sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    e_enter_d    = 1'b0;
    pipe_reset_d = pipe_reset_q;
    vector_d     = vector_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    case (state_q)
      S_RST: begin
        pipe_reset_d = 1'b1;
        if (cnt_q == RST_LAST) begin
          state_d      = S_RUN;
          cnt_d        = 4'd0;
          pipe_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RUN: begin
        pipe_reset_d = 1'b0;
        // An exception on the ERET instruction itself takes precedence over the return.
        if (req_s) begin
          e_enter_d = 1'b1;
          cause_d   = code_s;
          epc_d     = DELAY_SLOT ? (PC_WB - 32'd4) : PC_WB;
          vector_d  = ((code_s == 5'd2) || (code_s == 5'd3)) ? REFILL_VEC : GENERAL_VEC;
          state_d   = S_FLUSH;
          cnt_d     = 4'd0;
        end else if (ERET) begin
          state_d = S_FLUSH;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        pipe_reset_d = 1'b0;
        if (cnt_q == FLUSH_LAST) begin
          state_d = S_RUN;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d      = S_RST;
        cnt_d        = 4'd0;
        pipe_reset_d = 1'b1;
      end
    endcase
  end

  // State and output registers; RESET clears the entry strobe without waiting for a clock.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_RST;
      cnt_q        <= 4'd0;
      e_enter_q    <= 1'b0;
      pipe_reset_q <= 1'b1;
      vector_q     <= RESET_VEC;
      epc_q        <= 32'd0;
      cause_q      <= 5'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      e_enter_q    <= e_enter_d;
      pipe_reset_q <= pipe_reset_d;
      vector_q     <= vector_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
    end
  end

  assign E_ENTER    = e_enter_q;
  assign PIPE_RESET = pipe_reset_q;
  assign VECTOR     = vector_q;
  assign EPC        = epc_q;
  assign CAUSE      = cause_q;

endmodule

// File: tb/tb_excp_unit.sv
// Self-checking bench for excp_unit: directed scenarios plus random traffic, compared
// each cycle against a countdown-based reference model of the exception rules.
module tb_excp_unit;

  localparam int unsigned RST_CYCLES   = 4;
  localparam int unsigned FLUSH_CYCLES = 3;
  localparam logic [31:0] RESET_VEC    = 32'hBFC00000;
  localparam logic [31:0] REFILL_VEC   = 32'h80000000;
  localparam logic [31:0] GENERAL_VEC  = 32'h80000180;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ERET;
  logic        INT_COUNTER;
  logic [13:0] flags;
  logic [31:0] PC_WB;
  logic        DELAY_SLOT;
  logic        E_ENTER;
  logic        PIPE_RESET;
  logic [31:0] VECTOR;
  logic [31:0] EPC;
  logic [4:0]  CAUSE;

  int errors = 0;
  int checks = 0;

  // Flag order = priority order (index 0 highest): iADEL iTLBL IBE CpU RI OV SYSCALL BREAK
  // dADEL dADES dTLBL dTLBS dTLBMOD DBE.
  int codes [14] = '{4, 2, 6, 11, 10, 12, 8, 9, 4, 5, 2, 3, 1, 7};

  int          m_rst_left;
  int          m_blk;
  logic        m_e;
  logic        m_pr;
  logic [31:0] m_vec;
  logic [31:0] m_epc;
  logic [4:0]  m_cause;

  always #5 CLK = ~CLK;

  excp_unit #(
    .RST_CYCLES(RST_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES), .RESET_VEC(RESET_VEC),
    .REFILL_VEC(REFILL_VEC), .GENERAL_VEC(GENERAL_VEC)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ERET(ERET), .INT_COUNTER(INT_COUNTER),
    .SYSCALL(flags[6]), .BREAK(flags[7]), .RI(flags[4]), .CpU(flags[3]), .OV(flags[5]),
    .dTLBMOD(flags[12]), .dTLBL(flags[10]), .dTLBS(flags[11]), .dADEL(flags[8]),
    .dADES(flags[9]), .iTLBL(flags[1]), .iADEL(flags[0]), .IBE(flags[2]), .DBE(flags[13]),
    .PC_WB(PC_WB), .DELAY_SLOT(DELAY_SLOT),
    .E_ENTER(E_ENTER), .PIPE_RESET(PIPE_RESET), .VECTOR(VECTOR), .EPC(EPC), .CAUSE(CAUSE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rst_left = RST_CYCLES;
    m_blk      = 0;
    m_e        = 1'b0;
    m_pr       = 1'b1;
    m_vec      = RESET_VEC;
    m_epc      = 32'd0;
    m_cause    = 5'd0;
  endtask

  // One clock edge of the reference: reset countdown, then blackout countdown, then arbitration.
  task automatic model_edge();
    int code;
    m_e = 1'b0;
    if (RESET) begin
      model_reset();
    end else if (m_rst_left > 0) begin
      m_rst_left--;
      m_pr = (m_rst_left > 0);
    end else if (m_blk > 0) begin
      m_blk--;
    end else if ((flags != 14'd0) || INT_COUNTER) begin
      code = 0;
      for (int i = 13; i >= 0; i--) if (flags[i]) code = codes[i];
      m_e     = 1'b1;
      m_cause = 5'(code);
      m_epc   = DELAY_SLOT ? PC_WB - 32'd4 : PC_WB;
      m_vec   = (code == 2 || code == 3) ? REFILL_VEC : GENERAL_VEC;
      m_blk   = FLUSH_CYCLES;
    end else if (ERET) begin
      m_blk = FLUSH_CYCLES;
    end
  endtask

  task automatic compare();
    check("e_enter", {31'd0, E_ENTER}, {31'd0, m_e});
    check("pipe_reset", {31'd0, PIPE_RESET}, {31'd0, m_pr});
    check("vector", VECTOR, m_vec);
    check("epc", EPC, m_epc);
    check("cause", {27'd0, CAUSE}, {27'd0, m_cause});
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare();
  endtask

  task automatic drive(input logic [13:0] f, input logic irq, input logic er,
                       input logic [31:0] pc, input logic ds);
    flags       = f;
    INT_COUNTER = irq;
    ERET        = er;
    PC_WB       = pc;
    DELAY_SLOT  = ds;
  endtask

  task automatic idle(input int n);
    drive(14'd0, 1'b0, 1'b0, 32'h00400000, 1'b0);
    repeat (n) tick();
  endtask

  task automatic release_and_measure();
    int n;
    RESET = 1'b0;
    n = 0;
    while (PIPE_RESET && n < 20) begin
      tick();
      n++;
    end
    check("rst_len", 32'(n), 32'(RST_CYCLES));
  endtask

  initial begin
    int n;
    RESET = 1'b1;
    model_reset();
    drive(14'd1 << 6, 1'b0, 1'b0, 32'h00400000, 1'b0);
    #1;
    compare();
    repeat (3) tick();
    flags = 14'd0;
    release_and_measure();
    check("rst_vec_hold", VECTOR, RESET_VEC);

    drive(14'd1 << 4, 1'b0, 1'b0, 32'h00400010, 1'b0);
    tick();
    check("ri_enter", {31'd0, E_ENTER}, 32'd1);
    check("ri_cause", {27'd0, CAUSE}, 32'd10);
    check("ri_epc", EPC, 32'h00400010);
    check("ri_vec", VECTOR, GENERAL_VEC);
    idle(1);
    check("ri_one_cycle", {31'd0, E_ENTER}, 32'd0);
    idle(2);

    drive((14'd1 << 1) | (14'd1 << 5) | (14'd1 << 11), 1'b0, 1'b0, 32'h00400024, 1'b1);
    tick();
    check("prio_cause", {27'd0, CAUSE}, 32'd2);
    check("prio_epc", EPC, 32'h00400020);
    check("prio_vec", VECTOR, REFILL_VEC);

    drive(14'd1 << 13, 1'b0, 1'b0, 32'h00400028, 1'b0);
    repeat (FLUSH_CYCLES) begin
      tick();
      check("blackout_dbe", {31'd0, E_ENTER}, 32'd0);
    end
    drive(14'd0, 1'b1, 1'b0, 32'h00400030, 1'b0);
    tick();
    check("irq_first", {31'd0, E_ENTER}, 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!E_ENTER && n < 20);
    check("irq_gap", 32'(n), 32'(FLUSH_CYCLES + 1));
    check("irq_cause", {27'd0, CAUSE}, 32'd0);
    idle(FLUSH_CYCLES);

    drive(14'd1 << 7, 1'b0, 1'b1, 32'h00400040, 1'b0);
    tick();
    check("eret_break_cause", {27'd0, CAUSE}, 32'd9);
    idle(FLUSH_CYCLES);
    drive(14'd0, 1'b0, 1'b1, 32'h00400050, 1'b0);
    tick();
    check("eret_no_enter", {31'd0, E_ENTER}, 32'd0);
    drive(14'd1 << 5, 1'b0, 1'b0, 32'h00400054, 1'b0);
    tick();
    check("ov_ignored", {31'd0, E_ENTER}, 32'd0);
    idle(2);
    drive(14'd1 << 5, 1'b0, 1'b0, 32'h00400060, 1'b0);
    tick();
    check("ov_taken", {27'd0, CAUSE}, 32'd12);
    idle(FLUSH_CYCLES);

    drive(14'd1 << 6, 1'b0, 1'b0, 32'h00000000, 1'b1);
    tick();
    check("epc_wrap", EPC, 32'hFFFFFFFC);
    idle(FLUSH_CYCLES);

    drive(14'd1 << 4, 1'b0, 1'b0, 32'h00400070, 1'b0);
    tick();
    check("pre_async_enter", {31'd0, E_ENTER}, 32'd1);
    idle(1);
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    check("async_pr", {31'd0, PIPE_RESET}, 32'd1);
    check("async_vec", VECTOR, RESET_VEC);
    compare();
    @(negedge CLK);
    tick();
    release_and_measure();

    for (int k = 0; k < 400; k++) begin
      logic [13:0] f;
      for (int b = 0; b < 14; b++) f[b] = ($urandom_range(15) == 0);
      drive(f, $urandom_range(7) == 0, $urandom_range(7) == 0,
            {$urandom_range(32'h3FFFFFFF), 2'b00}, 1'($urandom_range(1)));
      if ($urandom_range(99) == 0) begin
        RESET = 1'b1;
        model_reset();
        #1;
        compare();
      end else begin
        RESET = 1'b0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
